// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-style front end.
// Fetch FSM states, widths and reset defaults.
package mips_pkg;

  localparam int XLEN = 32;
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/pc_next.sv
// Next-PC selection: sequential +4, branch and jump targets.
// Jump beats branch; targets are relative to the held instruction.
module pc_next #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_base,
  input  logic            i_br_taken,
  input  logic [15:0]     i_br_offset,
  input  logic            i_jmp,
  input  logic [25:0]     i_jmp_target,
  output logic [XLEN-1:0] o_pc_inc,
  output logic            o_redirect,
  output logic [XLEN-1:0] o_target
);

  logic [XLEN-1:0] w_br_off;
  logic [XLEN-1:0] w_br_tgt;
  logic [XLEN-1:0] w_jmp_tgt;

  // Candidate addresses, all with natural 32-bit wraparound.
  always_comb begin
    w_br_off  = {{(XLEN-18){i_br_offset[15]}}, i_br_offset, 2'b00};
    w_br_tgt  = i_base + w_br_off;
    w_jmp_tgt = {i_base[XLEN-1:XLEN-4], i_jmp_target, 2'b00};
    o_pc_inc  = i_pc + XLEN'(4);
  end

  // Redirect select; both requests may be active together.
  always_comb begin
    o_redirect = 1'b0;
    o_target   = o_pc_inc;
    priority case (1'b1)
      i_jmp: begin
        o_redirect = 1'b1;
        o_target   = w_jmp_tgt;
      end
      i_br_taken: begin
        o_redirect = 1'b1;
        o_target   = w_br_tgt;
      end
      default: begin
        o_redirect = 1'b0;
        o_target   = o_pc_inc;
      end
    endcase
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, single-outstanding imem reads,
// valid/ready hand-off to decode and branch/jump redirects.
module instr_fetch #(
  parameter int XLEN = mips_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = mips_pkg::RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4,
  input  logic            id_ready,
  input  logic            br_taken,
  input  logic [15:0]     br_offset,
  input  logic            jmp,
  input  logic [25:0]     jmp_target
);

  import mips_pkg::fetch_state_e;
  import mips_pkg::FETCH;
  import mips_pkg::WAIT;
  import mips_pkg::HOLD;
  import mips_pkg::DROP;

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_live;

  logic            w_req;
  logic            w_redirect;
  logic [XLEN-1:0] w_pc_inc;
  logic [XLEN-1:0] w_target;

  // r_live holds off the first request until a clock after reset.
  assign w_req     = r_live && (r_state == FETCH);
  assign imem_req  = w_req;
  assign imem_addr = r_pc;

  pc_next #(
    .XLEN(XLEN)
  ) u_pc_next (
    .i_pc         (r_pc),
    .i_base       (if_pc_plus4),
    .i_br_taken   (br_taken),
    .i_br_offset  (br_offset),
    .i_jmp        (jmp),
    .i_jmp_target (jmp_target),
    .o_pc_inc     (w_pc_inc),
    .o_redirect   (w_redirect),
    .o_target     (w_target)
  );

  // Fetch FSM with registered decode-facing outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= FETCH;
      r_pc        <= RESET_PC;
      r_live      <= 1'b0;
      if_valid    <= 1'b0;
      if_instr    <= '0;
      if_pc       <= '0;
      if_pc_plus4 <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_redirect) begin
        r_pc <= w_target;
      end
      unique case (r_state)
        FETCH: begin
          if (w_req) begin
            r_state <= w_redirect ? DROP : WAIT;
          end
        end
        WAIT: begin
          if (w_redirect) begin
            r_state <= imem_rvalid ? FETCH : DROP;
          end else if (imem_rvalid) begin
            if_instr    <= imem_rdata;
            if_pc       <= r_pc;
            if_pc_plus4 <= w_pc_inc;
            if_valid    <= 1'b1;
            r_state     <= HOLD;
          end
        end
        HOLD: begin
          if (w_redirect) begin
            if_valid <= 1'b0;
            r_state  <= FETCH;
          end else if (id_ready) begin
            r_pc     <= w_pc_inc;
            if_valid <= 1'b0;
            r_state  <= FETCH;
          end
        end
        DROP: begin
          if (imem_rvalid) begin
            r_state <= FETCH;
          end
        end
        default: begin
          r_state <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction-fetch stage that sits directly upstream of the opcode decoder/control unit. It holds the PC and issues word reads to instruction memory over a single-outstanding request/response interface. It presents the fetched instruction, its PC and PC+4 to decode with a valid/ready handshake, and accepts branch/jump redirects from decode/execute.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned)
XLEN, 32, address/instruction width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  read request strobe, one cycle per request
imem_addr  out  XLEN  word-aligned read address, valid with imem_req
imem_rvalid  in  1  read data valid, at least 1 cycle after imem_req
imem_rdata  in  XLEN  read data, valid with imem_rvalid
if_valid  out  1  fetched instruction held for decode
if_instr  out  XLEN  instruction; bits [31:26] drive the decoder opcode
if_pc  out  XLEN  address of if_instr
if_pc_plus4  out  XLEN  if_pc + 4
id_ready  in  1  decode accepts if_instr this cycle
br_taken  in  1  redirect: branch taken (Branch AND zero), relative to the held instruction
br_offset  in  16  branch immediate
jmp  in  1  redirect: J-type jump, relative to the held instruction
jmp_target  in  26  jump target field

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=FETCH, if_valid=0, if_instr=0, if_pc=0, if_pc_plus4=0, imem_req=0. imem_addr follows pc.
- States:
  - FETCH: imem_req=1, imem_addr=pc. Next state is WAIT, or DROP on redirect.
  - WAIT: awaits imem_rvalid. On rvalid with no redirect: capture if_instr=imem_rdata, if_pc=pc, if_pc_plus4=pc+4, set if_valid=1, go to HOLD.
  - HOLD: if_valid=1. On id_ready: pc<=pc+4, if_valid<=0, go to FETCH.
  - DROP: a request is outstanding whose data must be discarded. On imem_rvalid, discard the data and go to FETCH.
- Latency: request in cycle N, rvalid at N+k (k>=1), if_valid at N+k+1. Sustained throughput is one instruction per 3 cycles when k=1.
- Redirect target:
  - jmp: {if_pc_plus4[31:28], jmp_target, 2'b00}.
  - br_taken: if_pc_plus4 + (sign_extend(br_offset) << 2), 32-bit wraparound.
  - jmp has priority over br_taken. Redirect is honoured in every state, and the new pc is written on the same edge.
- Redirect per state:
  - HOLD: if_valid<=0, go to FETCH. A simultaneous id_ready is ignored; the redirect wins and pc is not incremented.
  - FETCH: the request is still issued. Go to DROP.
  - WAIT without rvalid: go to DROP.
  - WAIT with rvalid: discard the data, go to FETCH.
  - DROP: pc is updated and the state stays DROP, unless rvalid arrives the same cycle, in which case go to FETCH.
- if_instr, if_pc and if_pc_plus4 are stable while if_valid=1.
- imem_req is never asserted while a request is outstanding.
- pc increment wraps 32'hFFFF_FFFC to 0.
- Reset mid-operation aborts any outstanding request. A late imem_rvalid arriving after reset release in FETCH is ignored.

Decomposition:
- Shared package (mips_pkg): XLEN, opcode field position [31:26], RESET_PC default, and fetch state enum {FETCH, WAIT, HOLD, DROP}.
- Sub-module: pc_next (combinational next-PC adder/mux: +4, branch target, jump target, priority).

Test Plan:
- Reset then imem_rvalid 1 cycle after each req, id_ready=1 -> imem_addr sequence 0x0, 0x4, 0x8; if_instr matches rdata; if_pc_plus4 = if_pc+4.
- Hold id_ready=0 for 5 cycles with if_valid=1 -> outputs stable, no imem_req, pc unchanged.
- In HOLD with if_pc=0x100: br_taken=1, br_offset=16'hFFFF -> next imem_addr=0x100; br_offset=0x0003 -> next imem_addr=0x110.
- jmp=1, jmp_target=26'h0000040, if_pc_plus4=0x0040_0008 -> next imem_addr=0x0000_0100. With br_taken=1 simultaneously -> jump target still wins.
- Redirect in WAIT with rvalid delayed 3 cycles -> stale rdata never appears on if_instr; next request goes to the target address; only one outstanding request at a time.
- Drop rst_n mid-WAIT -> outputs return to reset values immediately; first request after release is to RESET_PC.
